id_control_unit: RTL and testbench
==================================

# id_control_unit

Instruction-decode control unit for the pipelined MIPS core. It decodes the 32-bit instruction in the ID stage into the datapath control word, including the 4-bit ALU-op code consumed by the EX-stage ALU control decoder. The control word is registered into the ID/EX boundary. The block supports stall, flush and halt, and keeps a count of retired-to-EX instructions for the debug unit.

## Interface
- No parameters.
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_instruction  in  32  instruction from IF/ID; opcode = [31:26], func = [5:0].
- i_valid  in  1  i_instruction holds a real instruction.
- i_stall  in  1  hold the registered outputs (load-use hazard).
- i_flush  in  1  load a bubble (taken branch/jump).
- o_ALUop  out  4  ALU-op code for the EX-stage ALU control decoder.
- o_regDst, o_ALUsrc, o_memRead, o_memWrite, o_memToReg, o_regWrite  out  1 each  classic MIPS controls.
- o_mem_width  out  2  00 byte, 01 half, 11 word.
- o_mem_unsigned  out  1  zero-extend the load.
- o_branch  out  2  00 none, 01 BEQ, 10 BNE.
- o_jump  out  2  00 none, 01 J/JAL, 10 JR/JALR.
- o_link  out  1  write PC+8 to the destination (JAL→r31, JALR→rd).
- o_valid  out  1  the registered control word is a real instruction.
- o_illegal  out  1  one-cycle pulse: an unknown opcode was decoded.
- o_halt  out  1  sticky: HLT was decoded.
- o_instr_count  out  32  number of instructions accepted into EX.

## Operation
- FSM has two states, RUN and HALTED. Reset enters RUN.
- An instruction is accepted when the state is RUN, i_valid=1, i_stall=0 and i_flush=0.
- Update priority each edge: reset > flush > stall > decode.
- Bubble: all enables (regWrite, memRead, memWrite, branch, jump, link) are 0, o_ALUop=0000, o_valid=0, all other controls 0.
- Decode by opcode:
  - 000000 R-type: o_ALUop=0000, regDst=1, regWrite=1.
    - func 001000 JR: jump=10, regWrite=0.
    - func 001001 JALR: jump=10, link=1, regWrite=1.
  - Loads, all with o_ALUop=0001, ALUsrc=1, memRead=1, memToReg=1, regWrite=1:
    - 100000 LB: width 00, unsigned 0.
    - 100001 LH: width 01, unsigned 0.
    - 100011 LW: width 11.
    - 100100 LBU: width 00, unsigned 1.
    - 100101 LHU: width 01, unsigned 1.
    - 100111 LWU: width 11, unsigned 1.
  - Stores, all with o_ALUop=0001, ALUsrc=1, memWrite=1: 101000 SB (width 00), 101001 SH (width 01), 101011 SW (width 11).
  - Immediates 001000 ADDI, 001010 SLTI, 001100 ANDI, 001101 ORI, 001110 XORI, 001111 LUI:
    - o_ALUop = opcode[3:0] (1000, 1010, 1100, 1101, 1110, 1111).
    - ALUsrc=1, regWrite=1, regDst=0.
  - 000100 BEQ: branch=01. 000101 BNE: branch=10. Both use o_ALUop=0001; the comparison is done in ID.
  - 000010 J: jump=01. 000011 JAL: jump=01, link=1, regWrite=1.
  - 111111 HLT: the output is a bubble, o_halt=1, and the FSM goes to HALTED.
  - Any other opcode: bubble plus an o_illegal pulse. Does not increment the counter.
- HALTED:
  - All inputs are ignored; outputs stay a bubble with o_halt=1 and the counter frozen.
  - Only reset exits HALTED.
- o_instr_count increments by 1 per accepted legal instruction, HLT included. It wraps from 0xFFFFFFFF to 0.

## Timing
- Latency: 1 cycle. The control word for the instruction presented at edge N is visible after edge N.
- Reset (i_reset=0 at an edge): all outputs 0, o_instr_count=0, state RUN. This holds even mid-stall or while HALTED.
- Stall:
  - All outputs and the counter hold their previous values; o_illegal drops to 0.
  - Stalled instructions are re-presented by IF/ID and are not counted twice.
- Flush: a bubble appears after the edge and the counter does not change. Flush together with stall: the flush wins.
- i_valid=0 in RUN: bubble; no count, no illegal pulse.
- HLT with stall or flush asserted is not accepted, so no halt occurs.
- o_illegal is high for exactly the one cycle after the accepting edge.

## Test plan
- Reset: hold i_reset=0 for 2 cycles → all outputs 0, count 0. Then send ADD (0x00221820) → next cycle o_ALUop=0000, regDst=1, regWrite=1, o_valid=1, count=1.
- Sweep: LW, SB, ADDI, ANDI, ORI, XORI, SLTI, LUI, BEQ, BNE, J, JAL, JR, JALR, LBU → each field matches the decode list above, e.g. ORI gives o_ALUop=1101, ALUsrc=1; LBU gives width 00, unsigned 1. Count=15.
- Hazards:
  - Stall 3 cycles on LW → outputs unchanged and count unchanged.
  - Flush during SW → bubble, memWrite=0.
  - Stall and flush together → bubble.
- Illegal opcode 0x1C000000 → one-cycle o_illegal=1, bubble, count unchanged.
- HLT (0xFC000000) followed by ADDs → o_halt=1, bubbles, count frozen. Then reset → RUN, o_halt=0.
- Counter wrap: preset via 2^32 accepted instructions (forced state allowed) → 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/id_control_unit_if.sv
// IF/ID-to-control-unit bundle: instruction + qualifiers in, registered ID/EX control word out.
// Master is the pipeline front end, slave is id_control_unit.
interface id_control_unit_if;
  logic [31:0] i_instruction;
  logic        i_valid;
  logic        i_stall;
  logic        i_flush;

  logic [3:0]  o_ALUop;
  logic        o_regDst;
  logic        o_ALUsrc;
  logic        o_memRead;
  logic        o_memWrite;
  logic        o_memToReg;
  logic        o_regWrite;
  logic [1:0]  o_mem_width;
  logic        o_mem_unsigned;
  logic [1:0]  o_branch;
  logic [1:0]  o_jump;
  logic        o_link;
  logic        o_valid;
  logic        o_illegal;
  logic        o_halt;
  logic [31:0] o_instr_count;

  modport master (
    output i_instruction, i_valid, i_stall, i_flush,
    input  o_ALUop, o_regDst, o_ALUsrc, o_memRead, o_memWrite, o_memToReg,
           o_regWrite, o_mem_width, o_mem_unsigned, o_branch, o_jump, o_link,
           o_valid, o_illegal, o_halt, o_instr_count
  );

  modport slave (
    input  i_instruction, i_valid, i_stall, i_flush,
    output o_ALUop, o_regDst, o_ALUsrc, o_memRead, o_memWrite, o_memToReg,
           o_regWrite, o_mem_width, o_mem_unsigned, o_branch, o_jump, o_link,
           o_valid, o_illegal, o_halt, o_instr_count
  );
endinterface

// File: rtl/id_control_unit.sv
// MIPS ID-stage decoder registering the control word into ID/EX; 1-cycle latency.
// Stall holds the word and counter, flush loads a bubble (flush wins), HLT parks the unit until reset.
module id_control_unit (
  input  logic               i_clk,
  input  logic               i_reset,
  id_control_unit_if.slave   bus
);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] mem_width;
    logic       mem_unsigned;
    logic [1:0] branch;
    logic [1:0] jump;
    logic       link;
    logic       valid;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_HLT   = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  state_t      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instr_count_q, instr_count_d;

  ctrl_t       dec;
  logic        dec_illegal;
  logic        dec_halt;
  logic [5:0]  opcode;
  logic [5:0]  func;

  assign opcode = bus.i_instruction[31:26];
  assign func   = bus.i_instruction[5:0];

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec_illegal = 1'b0;
    dec_halt    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        if (func == FN_JR) begin
          dec.jump      = 2'b10;
          dec.reg_write = 1'b0;
        end else if (func == FN_JALR) begin
          dec.jump = 2'b10;
          dec.link = 1'b1;
        end
      end
      // opcode[2] selects zero-extension, opcode[1:0] the access size (00/01/11)
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111: begin
        dec.alu_op       = 4'b0001;
        dec.alu_src      = 1'b1;
        dec.mem_read     = 1'b1;
        dec.mem_to_reg   = 1'b1;
        dec.reg_write    = 1'b1;
        dec.mem_width    = (opcode[1:0] == 2'b11) ? 2'b11 : {1'b0, opcode[0]};
        dec.mem_unsigned = opcode[2];
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec.alu_op    = 4'b0001;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.mem_width = (opcode[1:0] == 2'b11) ? 2'b11 : {1'b0, opcode[0]};
      end
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec.alu_op    = opcode[3:0];
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_op = 4'b0001;
        dec.branch = 2'b01;
      end
      OP_BNE: begin
        dec.alu_op = 4'b0001;
        dec.branch = 2'b10;
      end
      OP_J: begin
        dec.jump = 2'b01;
      end
      OP_JAL: begin
        dec.jump      = 2'b01;
        dec.link      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_HLT: begin
        dec      = '0;
        dec_halt = 1'b1;
      end
      default: begin
        dec         = '0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ctrl_d        = ctrl_q;
    illegal_d     = 1'b0;
    instr_count_d = instr_count_q;
    if (state_q == HALTED) begin
      ctrl_d = '0;
    end else if (bus.i_flush) begin
      ctrl_d = '0;
    end else if (bus.i_stall) begin
      ctrl_d = ctrl_q;
    end else if (!bus.i_valid) begin
      ctrl_d = '0;
    end else if (dec_illegal) begin
      ctrl_d    = '0;
      illegal_d = 1'b1;
    end else begin
      ctrl_d        = dec;
      instr_count_d = instr_count_q + 32'd1;
      if (dec_halt) begin
        state_d = HALTED;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q       <= RUN;
      ctrl_q        <= '0;
      illegal_q     <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      illegal_q     <= illegal_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.o_ALUop        = ctrl_q.alu_op;
  assign bus.o_regDst       = ctrl_q.reg_dst;
  assign bus.o_ALUsrc       = ctrl_q.alu_src;
  assign bus.o_memRead      = ctrl_q.mem_read;
  assign bus.o_memWrite     = ctrl_q.mem_write;
  assign bus.o_memToReg     = ctrl_q.mem_to_reg;
  assign bus.o_regWrite     = ctrl_q.reg_write;
  assign bus.o_mem_width    = ctrl_q.mem_width;
  assign bus.o_mem_unsigned = ctrl_q.mem_unsigned;
  assign bus.o_branch       = ctrl_q.branch;
  assign bus.o_jump         = ctrl_q.jump;
  assign bus.o_link         = ctrl_q.link;
  assign bus.o_valid        = ctrl_q.valid;
  assign bus.o_illegal      = illegal_q;
  assign bus.o_halt         = (state_q == HALTED);
  assign bus.o_instr_count  = instr_count_q;

endmodule

// File: tb/tb_id_control_unit.sv
// Directed bench for id_control_unit: driver queues expected words, monitor compares one cycle later.
module tb_id_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_control_unit_if bus ();

  id_control_unit dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [20:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;
  exp_t        mon_e;
  string       mon_n;
  logic [20:0] got_ctl;

  always_comb got_ctl = {bus.o_ALUop, bus.o_regDst, bus.o_ALUsrc, bus.o_memRead, bus.o_memWrite,
                         bus.o_memToReg, bus.o_regWrite, bus.o_mem_width, bus.o_mem_unsigned,
                         bus.o_branch, bus.o_jump, bus.o_link, bus.o_valid, bus.o_illegal, bus.o_halt};

  // Expected control bits in output order: alu, regDst, ALUsrc, memRead, memWrite, memToReg,
  // regWrite, width, unsigned, branch, jump, link.
  function automatic logic [17:0] cw(input logic [3:0] alu, input logic rd, input logic as,
                                     input logic mr, input logic mw, input logic m2r,
                                     input logic rw, input logic [1:0] w, input logic u,
                                     input logic [1:0] br, input logic [1:0] jp, input logic l);
    return {alu, rd, as, mr, mw, m2r, rw, w, u, br, jp, l};
  endfunction

  function automatic logic [20:0] vw(input logic [17:0] c);
    return {c, 3'b100};
  endfunction

  localparam logic [20:0] BUBBLE = 21'b0;
  localparam logic [20:0] ILLEG  = 21'b010;
  localparam logic [20:0] HALTW  = 21'b001;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if (got_ctl !== mon_e.ctl || bus.o_instr_count !== mon_e.cnt) begin
        errors++;
        $display("FAIL %s: got ctl=%b cnt=%h, expected ctl=%b cnt=%h",
                 mon_n, got_ctl, bus.o_instr_count, mon_e.ctl, mon_e.cnt);
      end
    end
  end

  task automatic step(input string n, input logic r, input logic [31:0] ins, input logic v,
                      input logic st, input logic fl, input logic [20:0] ectl, input logic inc);
    exp_t e;
    @(negedge clk);
    rst_n             = r;
    bus.i_instruction = ins;
    bus.i_valid       = v;
    bus.i_stall       = st;
    bus.i_flush       = fl;
    if (!r) exp_cnt = 32'd0;
    else if (inc) exp_cnt = exp_cnt + 32'd1;
    e.ctl = r ? ectl : BUBBLE;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  logic [31:0] sw_ins [15];
  logic [17:0] sw_cw  [15];
  string       sw_nm  [15];
  logic [17:0] c_r, c_lw;

  localparam logic [31:0] ADD = 32'h0022_1820;
  localparam logic [31:0] LW  = 32'h8C22_0004;
  localparam logic [31:0] SW  = 32'hAC22_0004;
  localparam logic [31:0] ILL = 32'h1C00_0000;
  localparam logic [31:0] HLT = 32'hFC00_0000;

  initial begin
    bus.i_instruction = '0;
    bus.i_valid       = 1'b0;
    bus.i_stall       = 1'b0;
    bus.i_flush       = 1'b0;

    c_r  = cw(4'h0, 1, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0);
    c_lw = cw(4'h1, 0, 1, 1, 0, 1, 1, 2'b11, 0, 2'b00, 2'b00, 0);

    sw_ins[0]  = LW;            sw_nm[0]  = "lw";   sw_cw[0]  = c_lw;
    sw_ins[1]  = 32'hA022_0004; sw_nm[1]  = "sb";   sw_cw[1]  = cw(4'h1, 0, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    sw_ins[2]  = 32'h2022_0005; sw_nm[2]  = "addi"; sw_cw[2]  = cw(4'h8, 0, 1, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0);
    sw_ins[3]  = 32'h3022_0005; sw_nm[3]  = "andi"; sw_cw[3]  = cw(4'hC, 0, 1, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0);
    sw_ins[4]  = 32'h3422_0005; sw_nm[4]  = "ori";  sw_cw[4]  = cw(4'hD, 0, 1, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0);
    sw_ins[5]  = 32'h3822_0005; sw_nm[5]  = "xori"; sw_cw[5]  = cw(4'hE, 0, 1, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0);
    sw_ins[6]  = 32'h2822_0005; sw_nm[6]  = "slti"; sw_cw[6]  = cw(4'hA, 0, 1, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0);
    sw_ins[7]  = 32'h3C02_1234; sw_nm[7]  = "lui";  sw_cw[7]  = cw(4'hF, 0, 1, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0);
    sw_ins[8]  = 32'h1022_0003; sw_nm[8]  = "beq";  sw_cw[8]  = cw(4'h1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0);
    sw_ins[9]  = 32'h1422_0003; sw_nm[9]  = "bne";  sw_cw[9]  = cw(4'h1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b00, 0);
    sw_ins[10] = 32'h0800_0010; sw_nm[10] = "j";    sw_cw[10] = cw(4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0);
    sw_ins[11] = 32'h0C00_0010; sw_nm[11] = "jal";  sw_cw[11] = cw(4'h0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b01, 1);
    sw_ins[12] = 32'h03E0_0008; sw_nm[12] = "jr";   sw_cw[12] = cw(4'h0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b10, 0);
    sw_ins[13] = 32'h0020_1809; sw_nm[13] = "jalr"; sw_cw[13] = cw(4'h0, 1, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b10, 1);
    sw_ins[14] = 32'h9022_0000; sw_nm[14] = "lbu";  sw_cw[14] = cw(4'h1, 0, 1, 1, 0, 1, 1, 2'b00, 1, 2'b00, 2'b00, 0);

    step("reset0", 0, ADD, 1, 0, 0, BUBBLE, 0);
    step("reset1", 0, ADD, 1, 0, 0, BUBBLE, 0);
    step("add", 1, ADD, 1, 0, 0, vw(c_r), 1);
    #2;
    checks++;
    if (bus.o_instr_count !== 32'd1) begin
        errors++;
        $display("FAIL add_count: got cnt=%h, expected 1", bus.o_instr_count);
    end

    step("reset_sweep", 0, ADD, 1, 0, 0, BUBBLE, 0);
    for (int i = 0; i < 15; i++) begin
      step(sw_nm[i], 1, sw_ins[i], 1, 0, 0, vw(sw_cw[i]), 1);
    end

    step("lw_hz", 1, LW, 1, 0, 0, vw(c_lw), 1);
    for (int i = 0; i < 3; i++) begin
      step("stall_hold", 1, ADD, 1, 1, 0, vw(c_lw), 0);
    end
    step("flush_sw", 1, SW, 1, 0, 1, BUBBLE, 0);
    step("stall_flush", 1, ADD, 1, 1, 1, BUBBLE, 0);
    step("add_resume", 1, ADD, 1, 0, 0, vw(c_r), 1);
    step("valid0", 1, ADD, 0, 0, 0, BUBBLE, 0);

    step("illegal", 1, ILL, 1, 0, 0, ILLEG, 0);
    #2;
    checks++;
    if (bus.o_illegal !== 1'b1) begin
        errors++;
        $display("FAIL illegal_pulse: got o_illegal=%b, expected 1", bus.o_illegal);
    end
    step("illegal_stall", 1, ADD, 1, 1, 0, BUBBLE, 0);
    step("illegal_drop", 1, ADD, 1, 0, 0, vw(c_r), 1);

    step("hlt_stall", 1, HLT, 1, 1, 0, vw(c_r), 0);
    step("hlt_flush", 1, HLT, 1, 0, 1, BUBBLE, 0);
    step("hlt", 1, HLT, 1, 0, 0, HALTW, 1);
    #2;
    checks++;
    if (bus.o_halt !== 1'b1) begin
        errors++;
        $display("FAIL hlt_sticky: got o_halt=%b, expected 1", bus.o_halt);
    end
    for (int i = 0; i < 3; i++) begin
      step("halted_add", 1, ADD, 1, 0, 0, HALTW, 0);
    end
    step("halted_flush", 1, ILL, 1, 0, 1, HALTW, 0);
    step("reset_halted", 0, ADD, 1, 0, 0, BUBBLE, 0);
    #2;
    checks++;
    if (bus.o_halt !== 1'b0) begin
        errors++;
        $display("FAIL reset_exit_halt: got o_halt=%b, expected 0", bus.o_halt);
    end
    step("add_after_halt", 1, ADD, 1, 0, 0, vw(c_r), 1);
    step("lw_before_rst", 1, LW, 1, 0, 0, vw(c_lw), 1);
    step("reset_stall", 0, ADD, 1, 1, 0, BUBBLE, 0);
    step("add_after_rst", 1, ADD, 1, 0, 0, vw(c_r), 1);

    #2;
    force dut.instr_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.instr_count_q;
    exp_cnt = 32'hFFFF_FFFE;
    step("wrap_max", 1, ADD, 1, 0, 0, vw(c_r), 1);
    step("wrap_zero", 1, ADD, 1, 0, 0, vw(c_r), 1);
    #2;
    checks++;
    if (bus.o_instr_count !== 32'd0) begin
        errors++;
        $display("FAIL wrap_check: got cnt=%h, expected 0", bus.o_instr_count);
    end

    @(negedge clk);
    bus.i_valid = 1'b0;
    @(posedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    if (errors != 0) $display("FAIL: %0d errors", errors);
    else $display("PASS");
    $finish;
  end

endmodule
